trd_ctrl_unit: RTL
==================

# trd_ctrl_unit

Parametrised thread-control unit that owns the per-thread state table of the multithreaded core. It consumes the thread-control commands (sleep, wake, kill, init) retired by the write-back stage. It allocates hardware thread IDs for init, announces newly spawned threads and their start PC to fetch, and picks the next thread to fetch in round-robin order among active threads. It sits between write-back (command side) and fetch (grant side).

## Interface
- NUM_TRD, 8, number of hardware threads (2..32)
- TRD_W, $clog2(NUM_TRD), thread-ID width (derived, not overridden)
- XLEN, 32, data/PC width
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  WB command valid, already qualified with write enable and not flushed
- cmd_op  in  3  001 sleep, 010 wake, 011 kill, 111 init; other codes are no-ops
- cmd_trd  in  TRD_W  issuing thread (the target of sleep/kill)
- cmd_target  in  TRD_W  target thread of wake
- cmd_pc  in  XLEN  start PC for init
- new_trd  out  TRD_W  lowest-numbered FREE thread (the init writeback value)
- alloc_ok  out  1  at least one FREE thread exists
- spawn_valid  out  1  one-cycle pulse: a thread was initialised last cycle
- spawn_trd  out  TRD_W  thread ID being spawned
- spawn_pc  out  XLEN  start PC of the spawned thread
- fetch_ready  in  1  fetch accepts the offered thread this cycle
- fetch_valid  out  1  an ACTIVE thread is offered
- fetch_trd  out  TRD_W  offered thread
- active_mask  out  NUM_TRD  bit i = thread i ACTIVE
- sleep_mask  out  NUM_TRD  bit i = thread i SLEEP

## Operation
- Each thread has a 2-bit state in a register file: FREE, ACTIVE, SLEEP.
- Reset: thread 0 is ACTIVE and all others are FREE. rr_last = NUM_TRD-1, so thread 0 is offered first. spawn_valid=0, spawn_trd=0, spawn_pc=0.
- Sleep (001): if cmd_trd is ACTIVE, it becomes SLEEP. Otherwise no-op.
- Wake (010): if cmd_target is SLEEP, it becomes ACTIVE. If it is FREE or ACTIVE, no-op.
- Kill (011): if cmd_trd is ACTIVE or SLEEP, it becomes FREE. Thread 0 is the root thread and is never killed; a kill with cmd_trd=0 is ignored.
- Init (111) with alloc_ok=1:
  - thread new_trd goes FREE -> ACTIVE;
  - next cycle, spawn_valid=1, spawn_trd=that ID, spawn_pc=cmd_pc.
- Init with alloc_ok=0: no state change and no spawn. WB writes back new_trd regardless; software checks via a separate mechanism.
- new_trd is a combinational priority encode of FREE bits from registered state, lowest index first. It is 0 when none is free.
- Round-robin fetch selection:
  - fetch_trd is the first ACTIVE thread scanning rr_last+1, rr_last+2, … with modulo NUM_TRD wrap-around;
  - fetch_valid = |active_mask;
  - on fetch_valid & fetch_ready, rr_last <= fetch_trd;
  - a single active thread is offered every cycle.
- All-idle case: if no thread is ACTIVE, fetch_valid=0 and fetch_trd=0. rr_last holds.

## Timing
- Commands are sampled on the rising edge and state updates that edge. Masks, new_trd, alloc_ok and fetch outputs reflect the change in the following cycle.
- Fetch selection uses registered state only; fetch outputs are combinational from it.
  - A thread slept or killed in cycle N can still be granted in cycle N. Downstream flush logic discards it.
- Kill and grant of the same thread in one cycle: the kill takes effect and rr_last still updates.
- Init: spawn outputs are registered, so latency is exactly one cycle. spawn_pc/spawn_trd hold until the next init.
- One command per cycle. Commands whose target state does not match the precondition change nothing.
- Asynchronous reset mid-operation returns all state to reset values immediately. A pending spawn pulse is dropped.

## Test plan
- Reset then fetch_ready=1:
  - fetch_trd=0 every cycle and fetch_valid=1;
  - active_mask=8'h01, new_trd=1, alloc_ok=1.
- Init from thread 0 with cmd_pc=32'h0000_0400:
  - next cycle spawn_valid=1, spawn_trd=1, spawn_pc=0x400, active_mask=8'h03;
  - fetch alternates 0,1,0,1 with fetch_ready=1.
- Allocation exhaustion:
  - seven inits -> active_mask=8'hFF, alloc_ok=0;
  - an eighth init causes no spawn_valid and no state change.
- Sleep thread 2, then wake cmd_target=2:
  - sleep_mask bit 2 set one cycle after the sleep, and thread 2 is skipped by round-robin;
  - after the wake, thread 2 is offered again;
  - a wake to FREE thread 5 changes nothing.
- Kill thread 3 while ACTIVE: active_mask bit 3 clears and new_trd=3 (lowest free). Kill with cmd_trd=0: ignored.
- Fetch back-pressure with fetch_ready=0 and threads 0,1,4 ACTIVE: fetch_trd stays fixed. Release it: grants follow 0->1->4->0 wrap-around.

Source files
------------

// File: rtl/trd_ctrl_unit.sv
// Thread-control unit: per-thread FREE/ACTIVE/SLEEP table driven by write-back
// commands, thread allocation for init, spawn announcement and round-robin fetch pick.
module trd_ctrl_unit #(
    parameter  int unsigned NUM_TRD = 8,
    parameter  int unsigned XLEN    = 32,
    localparam int unsigned TRD_W   = $clog2(NUM_TRD)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    input  logic [TRD_W-1:0]   cmd_trd,
    input  logic [TRD_W-1:0]   cmd_target,
    input  logic [XLEN-1:0]    cmd_pc,
    output logic [TRD_W-1:0]   new_trd,
    output logic               alloc_ok,
    output logic               spawn_valid,
    output logic [TRD_W-1:0]   spawn_trd,
    output logic [XLEN-1:0]    spawn_pc,
    input  logic               fetch_ready,
    output logic               fetch_valid,
    output logic [TRD_W-1:0]   fetch_trd,
    output logic [NUM_TRD-1:0] active_mask,
    output logic [NUM_TRD-1:0] sleep_mask
);

    typedef enum logic [1:0] {
        TS_FREE   = 2'b00,
        TS_ACTIVE = 2'b01,
        TS_SLEEP  = 2'b10
    } trd_state_e;

    typedef enum logic [2:0] {
        OP_SLEEP = 3'b001,
        OP_WAKE  = 3'b010,
        OP_KILL  = 3'b011,
        OP_INIT  = 3'b111
    } cmd_op_e;

    trd_state_e         r_state     [NUM_TRD];
    trd_state_e         w_state_nxt [NUM_TRD];
    logic [TRD_W-1:0]   r_rr_last;
    logic [NUM_TRD-1:0] w_free_mask;
    logic [TRD_W-1:0]   w_idx;
    logic               w_init_fire;

    always_comb begin
        active_mask = '0;
        sleep_mask  = '0;
        w_free_mask = '0;
        for (int unsigned i = 0; i < NUM_TRD; i++) begin
            active_mask[i] = (r_state[i] == TS_ACTIVE);
            sleep_mask[i]  = (r_state[i] == TS_SLEEP);
            w_free_mask[i] = (r_state[i] == TS_FREE);
        end
    end

    // Scan high to low so the lowest free index is the last one written.
    always_comb begin
        new_trd = '0;
        for (int unsigned i = 0; i < NUM_TRD; i++) begin
            if (w_free_mask[NUM_TRD-1-i]) new_trd = TRD_W'(NUM_TRD-1-i);
        end
        alloc_ok = |w_free_mask;
    end

    // Walk offsets from farthest to nearest after rr_last; the nearest active wins.
    always_comb begin
        fetch_trd = '0;
        w_idx     = '0;
        for (int unsigned i = 0; i < NUM_TRD; i++) begin
            w_idx = TRD_W'((32'(r_rr_last) + NUM_TRD - i) % NUM_TRD);
            if (active_mask[w_idx]) fetch_trd = w_idx;
        end
        fetch_valid = |active_mask;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_fire = 1'b0;
        if (cmd_valid) begin
            case (cmd_op)
                OP_SLEEP: if (r_state[cmd_trd] == TS_ACTIVE) w_state_nxt[cmd_trd] = TS_SLEEP;
                OP_WAKE:  if (r_state[cmd_target] == TS_SLEEP) w_state_nxt[cmd_target] = TS_ACTIVE;
                OP_KILL:  if ((cmd_trd != '0) && (r_state[cmd_trd] != TS_FREE))
                              w_state_nxt[cmd_trd] = TS_FREE;
                OP_INIT:  if (alloc_ok) begin
                              w_init_fire          = 1'b1;
                              w_state_nxt[new_trd] = TS_ACTIVE;
                          end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_TRD; i++) begin
                r_state[i] <= (i == 0) ? TS_ACTIVE : TS_FREE;
            end
            r_rr_last   <= TRD_W'(NUM_TRD-1);
            spawn_valid <= 1'b0;
            spawn_trd   <= '0;
            spawn_pc    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            spawn_valid <= w_init_fire;
            if (w_init_fire) begin
                spawn_trd <= new_trd;
                spawn_pc  <= cmd_pc;
            end
            if (fetch_valid && fetch_ready) r_rr_last <= fetch_trd;
        end
    end

endmodule
